// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car path: motion codes, FSM states and
// the 6-bit car-state packing used by both the car controller and the prioritizer.
package elevator_pkg;

  localparam int FLOOR_W = 4;

  localparam logic [1:0] MOT_IDLE = 2'b00;
  localparam logic [1:0] MOT_UP   = 2'b01;
  localparam logic [1:0] MOT_DOWN = 2'b10;
  localparam logic [1:0] MOT_DOOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } car_state_e;

  function automatic logic [1:0] motion_of(input car_state_e s);
    logic [1:0] m;
    case (s)
      S_MOVE_UP:   m = MOT_UP;
      S_MOVE_DOWN: m = MOT_DOWN;
      S_DOOR:      m = MOT_DOOR;
      default:     m = MOT_IDLE;
    endcase
    return m;
  endfunction

  function automatic logic [FLOOR_W+1:0] pack_car_state(input logic [1:0] motion,
                                                        input logic [FLOOR_W-1:0] floor);
    return {motion, floor};
  endfunction

endpackage

// File: rtl/request_fifo.sv
// Circular request queue: registered pointers, head word read combinationally.
// Push when full and pop when empty are ignored.
module request_fifo
  import elevator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [FLOOR_W-1:0]       din,
  input  logic                     pop,
  output logic [FLOOR_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLOOR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a flush only has to clear the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/elevator_car_controller.sv
// Per-car controller: queues dispatched floors and walks the car floor by floor,
// holding the door at each stop. Handshake: a request transfers on the rising
// edge where req_valid && req_ready; req_ready is simply "queue not full".
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 10,
  parameter int DEPTH         = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DWELL_CYCLES  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [FLOOR_W-1:0]       req_floor,
  output logic                     req_ready,
  output logic [FLOOR_W-1:0]       floor,
  output logic [FLOOR_W+1:0]       state,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     req_err
);

  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DWELL_W  = $clog2(DWELL_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W:0]    FLOORS_LIM  = (FLOOR_W + 1)'(FLOORS);

  car_state_e          fsm, fsm_next;
  logic [FLOOR_W-1:0]  floor_next;
  logic [FLOOR_W-1:0]  target, target_next;
  logic [TRAVEL_W-1:0] travel_cnt, travel_next;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_next;
  logic [FLOOR_W-1:0]  head;
  logic [FLOOR_W-1:0]  floor_up, floor_down;
  logic                fifo_full, fifo_empty;
  logic                accept, in_range, push, pop;

  assign req_ready  = !fifo_full;
  assign accept     = req_valid && req_ready;
  assign in_range   = ({1'b0, req_floor} < FLOORS_LIM);
  assign push       = accept && in_range;
  assign floor_up   = floor + 1'b1;
  assign floor_down = floor - 1'b1;

  request_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (req_floor),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= S_IDLE;
      floor      <= '0;
      target     <= '0;
      travel_cnt <= '0;
      dwell_cnt  <= '0;
      req_err    <= 1'b0;
    end else begin
      fsm        <= fsm_next;
      floor      <= floor_next;
      target     <= target_next;
      travel_cnt <= travel_next;
      dwell_cnt  <= dwell_next;
      req_err    <= accept && !in_range;
    end
  end

  // Target is only loaded from the queue in IDLE, so requests arriving mid-trip
  // wait their turn and never redirect the car.
  always_comb begin
    fsm_next    = fsm;
    floor_next  = floor;
    target_next = target;
    travel_next = travel_cnt;
    dwell_next  = dwell_cnt;
    pop         = 1'b0;
    case (fsm)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          target_next = head;
          travel_next = '0;
          dwell_next  = '0;
          if (head > floor)      fsm_next = S_MOVE_UP;
          else if (head < floor) fsm_next = S_MOVE_DOWN;
          else                   fsm_next = S_DOOR;
        end
      end
      S_MOVE_UP: begin
        if (travel_cnt == TRAVEL_LAST) begin
          travel_next = '0;
          floor_next  = floor_up;
          if (floor_up == target) fsm_next = S_DOOR;
        end else begin
          travel_next = travel_cnt + 1'b1;
        end
      end
      S_MOVE_DOWN: begin
        if (travel_cnt == TRAVEL_LAST) begin
          travel_next = '0;
          floor_next  = floor_down;
          if (floor_down == target) fsm_next = S_DOOR;
        end else begin
          travel_next = travel_cnt + 1'b1;
        end
      end
      S_DOOR: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_next = '0;
          fsm_next   = S_IDLE;
        end else begin
          dwell_next = dwell_cnt + 1'b1;
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  // Built only from registers, so it moves on the same edge as fsm and floor.
  always_comb begin
    state = pack_car_state(motion_of(fsm), floor);
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller with default parameters; timing
// expectations are hand-derived (4 clocks per floor, 6 clocks of door).
module tb_elevator_car_controller;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_ready;
  logic [3:0] floor;
  logic [5:0] state;
  logic [2:0] pending;
  logic       req_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  bit ok;

  elevator_car_controller dut (
    .clk       (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_ready (req_ready),
    .floor     (floor),
    .state     (state),
    .pending   (pending),
    .req_err   (req_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, returning at the following falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [3:0] f);
    req_valid = 1'b1;
    req_floor = f;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_door(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state[5:4] == 2'b11) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("door_timeout", 0, 1);
  endtask

  task automatic wait_not_door();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (state[5:4] != 2'b11) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("leave_door_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_floor = 4'd0;

    // asynchronous reset, no clock edge yet
    #2 rst = 1'b1;
    #1;
    chk("rst_state", state, 6'b000000);
    chk("rst_floor", floor, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_pending", pending, 0);
    chk("rst_err", req_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("idle_after_rst", state, 6'b000000);

    // single trip 0 -> 3
    push_one(4'd3);
    chk("trip_pending", pending, 1);
    chk("trip_no_bypass", state, 6'b000000);
    tick(1);
    chk("trip_start_up", state, 6'b010000);
    chk("trip_popped", pending, 0);
    tick(3);
    chk("trip_still_f0", state, 6'b010000);
    tick(1);
    chk("trip_f1", state, 6'b010001);
    tick(4);
    chk("trip_f2", state, 6'b010010);
    tick(3);
    chk("trip_f2_late", state, 6'b010010);
    tick(1);
    chk("trip_door_f3", state, 6'b110011);
    tick(5);
    chk("trip_door_hold", state, 6'b110011);
    tick(1);
    chk("trip_idle_f3", state, 6'b000011);

    // down 3 -> 1
    push_one(4'd1);
    tick(1);
    chk("down_start", state, 6'b100011);
    tick(4);
    chk("down_f2", state, 6'b100010);
    tick(3);
    chk("down_f2_late", state, 6'b100010);
    tick(1);
    chk("down_door_f1", state, 6'b110001);
    tick(6);
    chk("down_idle_f1", state, 6'b000001);

    // same floor goes straight to door
    push_one(4'd1);
    chk("same_pending", pending, 1);
    tick(1);
    chk("same_door", state, 6'b110001);

    // fill the queue while the door is open
    foreach (exp_q[i]) exp_q.delete(i);
    begin
      logic [3:0] vec [4];
      vec[0] = 4'd5; vec[1] = 4'd7; vec[2] = 4'd2; vec[3] = 4'd9;
      for (int i = 0; i < 4; i++) begin
        chk("fill_ready", req_ready, 1);
        push_one(vec[i]);
        exp_q.push_back(vec[i]);
      end
    end
    chk("full_pending", pending, 4);
    chk("full_ready", req_ready, 0);
    chk("full_still_door", state, 6'b110001);
    push_one(4'd4);
    chk("full_refused_pending", pending, 4);
    chk("full_refused_ready", req_ready, 0);

    for (int i = 0; i < 4; i++) begin
      logic [3:0] e;
      wait_not_door();
      wait_door(ok);
      e = exp_q.pop_front();
      chk("serve_order", floor, e);
    end
    wait_not_door();
    tick(3);
    chk("served_all_idle", state, 6'b001001);
    chk("served_all_pending", pending, 0);

    // out-of-range request
    chk("err_quiet", req_err, 0);
    push_one(4'd12);
    chk("err_pulse", req_err, 1);
    chk("err_pending", pending, 0);
    chk("err_idle", state, 6'b001001);
    tick(1);
    chk("err_one_cycle", req_err, 0);
    tick(3);
    chk("err_car_stays", state, 6'b001001);

    // return to floor 0
    push_one(4'd0);
    wait_door(ok);
    chk("home_floor", floor, 0);
    wait_not_door();
    chk("home_idle", state, 6'b000000);

    // reset while moving up with two entries queued
    req_valid = 1'b1;
    req_floor = 4'd5;
    tick(1);
    req_floor = 4'd8;
    tick(1);
    chk("pushpop_pending", pending, 1);
    chk("pushpop_up", state, 6'b010000);
    tick(1);
    req_valid = 1'b0;
    chk("two_queued", pending, 2);
    tick(7);
    chk("mid_move_f2", state, 6'b010010);
    chk("mid_move_pending", pending, 2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", state, 6'b000000);
    chk("midrst_floor", floor, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick(4);
    chk("postrst_idle", state, 6'b000000);
    chk("postrst_pending", pending, 0);
    push_one(4'd1);
    tick(1);
    chk("postrst_trip", state, 6'b010000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
